// File: rtl/div_ratio_meter.sv
// Measures period and high time of a divided clock in reference-clock cycles and
// flags lock once LOCK_N consecutive periods match.
module div_ratio_meter #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LOCK_N = 4
) (
    input  logic             i_clk_in,
    input  logic             i_rst,
    input  logic             i_sig,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_lock,
    output logic             o_ovf
);

    localparam int unsigned      MW     = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [MW-1:0]    LockN  = MW'(LOCK_N);
    localparam logic [MW-1:0]    MOne   = MW'(1);

    typedef enum logic [1:0] {StIdle, StSeek, StMeas} state_e;

    state_e           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [MW-1:0]    mcnt_q, mcnt_d;
    logic             valid_q, valid_d;
    logic             lock_q, lock_d;
    logic             ovf_q, ovf_d;
    logic             rise;

    assign rise = s2_q & ~s3_q;

    always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
            state_q  <= StIdle;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            mcnt_q   <= '0;
            valid_q  <= 1'b0;
            lock_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= i_sig;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            mcnt_q   <= mcnt_d;
            valid_q  <= valid_d;
            lock_q   <= lock_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        period_d = period_q;
        high_d   = high_q;
        mcnt_d   = mcnt_q;
        valid_d  = 1'b0;
        lock_d   = lock_q;
        ovf_d    = ovf_q;

        if (!i_en) begin
            // Disable wins over everything; results are kept, tracking state is dropped.
            state_d = StIdle;
            cnt_d   = '0;
            hcnt_d  = '0;
            mcnt_d  = '0;
            lock_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StSeek;
                end
                StSeek: begin
                    if (rise) begin
                        cnt_d   = CntOne;
                        hcnt_d  = CntOne;
                        state_d = StMeas;
                    end
                end
                StMeas: begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = hcnt_q;
                        valid_d  = 1'b1;
                        cnt_d    = CntOne;
                        hcnt_d   = CntOne;
                        if (cnt_q == period_q && mcnt_q != '0) begin
                            mcnt_d = (mcnt_q >= LockN) ? LockN : mcnt_q + MOne;
                        end else begin
                            mcnt_d = MOne;
                        end
                        lock_d = (mcnt_d >= LockN);
                    end else if (cnt_q == CntMax) begin
                        ovf_d   = 1'b1;
                        mcnt_d  = '0;
                        lock_d  = 1'b0;
                        state_d = StSeek;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                        if (s2_q) begin
                            hcnt_d = hcnt_q + CntOne;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign o_period = period_q;
    assign o_high   = high_q;
    assign o_valid  = valid_q;
    assign o_lock   = lock_q;
    assign o_ovf    = ovf_q;

endmodule

// File: doc/div_ratio_meter.md
DIV_RATIO_METER -- requirements
Module: div_ratio_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of the period and high-time counters and outputs.
REQ-002 SHALL have parameter LOCK_N, default 4, giving the number of consecutive equal periods required for lock.
REQ-003 SHALL have port i_clk_in, input, 1, reference clock; the only clock in the block, all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_sig, input, 1, divided clock under test, treated as asynchronous data.
REQ-006 SHALL have port i_en, input, 1, measurement enable.
REQ-007 SHALL have port o_period, output, CNT_W, last measured period in i_clk_in cycles, rise to rise.
REQ-008 SHALL have port o_high, output, CNT_W, last measured high time in i_clk_in cycles.
REQ-009 SHALL have port o_valid, output, 1, one-cycle pulse marking new o_period/o_high.
REQ-010 SHALL have port o_lock, output, 1, high when the last LOCK_N measured periods are all equal.
REQ-011 SHALL have port o_ovf, output, 1, sticky flag for period counter saturation.

Function
REQ-012 SHALL sample i_sig through a 2-flop synchronizer s1->s2, plus delay flop s3; rise = s2 & ~s3.
REQ-013 SHALL implement FSM states IDLE, SEEK and MEAS.
REQ-014 IDLE SHALL go to SEEK when i_en=1; any state SHALL go to IDLE on the cycle after i_en=0.
REQ-015 SEEK SHALL wait for rise, then load cnt<=1 and hcnt<=1 and go to MEAS, with no o_valid.
REQ-016 In MEAS without rise: cnt<=cnt+1; hcnt<=hcnt+1 when s2=1, else hold.
REQ-017 In MEAS on rise, all registered in the same edge: o_period<=cnt; o_high<=hcnt; o_valid<=1; cnt<=1; hcnt<=1.
REQ-018 o_valid SHALL be 0 in every cycle other than the one following a MEAS rise.
REQ-019 Latency: o_valid SHALL be high after the 3rd i_clk_in edge, counting the edge that first samples i_sig=1.
REQ-020 Minimum measurable period SHALL be 2; a constant-high i_sig SHALL produce no rise and eventually overflow.
REQ-021 If cnt = 2^CNT_W-1 in MEAS without rise, the block SHALL set o_ovf=1, clear lock state, go to SEEK, and leave o_period/o_high unchanged.
REQ-022 o_ovf SHALL clear only on i_rst or in IDLE.
REQ-023 Lock counter mcnt SHALL update on each o_valid.
REQ-024 mcnt update rule:
- new period == o_period and mcnt != 0: mcnt<=mcnt+1, saturating at LOCK_N;
- otherwise: mcnt<=1.
REQ-025 o_lock SHALL equal (mcnt >= LOCK_N), registered, valid in the same cycle as o_valid.
REQ-026 mcnt SHALL clear to 0 on entering SEEK or IDLE.
REQ-027 In IDLE, o_period and o_high SHALL hold their last values; cnt, hcnt, mcnt, o_lock, o_ovf and o_valid SHALL be 0.
REQ-028 If rise and the saturation condition coincide, rise SHALL take priority: a normal measurement and no overflow.

Reset
REQ-029 On i_rst=1, the block SHALL set state=IDLE, s1=s2=s3=0, and clear cnt, hcnt, mcnt, o_period, o_high, o_valid, o_lock and o_ovf.
REQ-030 i_rst SHALL override i_en and every in-progress measurement, including mid-period reset.
REQ-031 After i_rst falls, the first o_valid SHALL require a SEEK rise followed by a full period.

Verification
REQ-032 i_en=1; i_sig repeating 1,0,0 (divide-by-3) -> o_valid every 3 cycles; o_period=3, o_high=1; o_lock=1 on the 4th valid.
REQ-033 i_sig repeating 1,1,0,0,0 -> o_period=5, o_high=2; switch to 1,1,0,0 -> first valid o_period=4 with o_lock=0; relock after 4 valids.
REQ-034 CNT_W=4; i_sig held 0 after one rise -> o_ovf=1 after 15 MEAS cycles; no o_valid; state SEEK; o_ovf stays 1 until i_en=0.
REQ-035 i_rst=1 pulsed mid-period during a locked divide-by-3 -> all outputs 0 next cycle; o_lock regained only after 4 fresh valids.
REQ-036 i_en dropped for 1 cycle while locked -> o_lock=0, o_period holds 3; after i_en returns, the first valid comes one full period after the SEEK rise.
